sap_control_sequencer: RTL and testbench

Control sequencer for the 8-bit register datapath (A register, B register, instruction register, ALU, program counter, MAR, RAM, output register). It steps a six-phase T-state machine: fetch (T0–T2), then execute (T3–T5) decoded from the 4-bit opcode held in the instruction register. Each T-state drives one control word of load/drive strobes onto the shared bus. It sits beside the register bank in the top-level wrapper, and its outputs connect directly to the register enables.

---
 rtl/sap_control_sequencer.sv | 153 +++++++++++++++
 tb/tb_sap_control_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// T-state control sequencer for the 8-bit register datapath: three fetch states,
// then up to three execute states decoded from the IR opcode, plus IDLE and HALT.
module sap_control_sequencer #(
    parameter bit FIXED_LEN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       run,
    input  logic       step_mode,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] tstate
);

    // state | meaning
    // T0    | PC onto bus, load MAR
    // T1    | increment PC
    // T2    | RAM onto bus, load IR
    // T3-T5 | execute, decoded from opcode
    // IDLE  | waiting for run
    // HALT  | stopped until reset
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        IDLE = 3'd6,
        HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t state;
    state_t end_state;
    logic   adv;
    logic   last;

    assign adv       = ena & (~step_mode | step);
    assign end_state = run ? T0 : IDLE;

    // Last execute state of the current instruction (HLT is caught separately in T3)
    always_comb begin
        last = 1'b0;
        if (FIXED_LEN) begin
            last = (state == T5);
        end else begin
            case (opcode)
                OP_LDA:         last = (state == T4);
                OP_ADD, OP_SUB: last = (state == T5);
                default:        last = (state == T3);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (adv) begin
            case (state)
                IDLE: if (run) state <= T0;
                T0:   state <= T1;
                T1:   state <= T2;
                T2:   state <= T3;
                T3: begin
                    if (opcode == OP_HLT) state <= HALT;
                    else if (last)        state <= end_state;
                    else                  state <= T4;
                end
                T4:   state <= last ? end_state : T5;
                T5:   state <= end_state;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes depend only on state and opcode, so run/step never reach them
    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ram_out  = 1'b0;
        ir_load  = 1'b0;
        ir_out   = 1'b0;
        a_load   = 1'b0;
        a_out    = 1'b0;
        b_load   = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        case (state)
            T0: begin
                pc_out   = 1'b1;
                mar_load = 1'b1;
            end
            T1: pc_inc = 1'b1;
            T2: begin
                ram_out = 1'b1;
                ir_load = 1'b1;
            end
            T3: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    ir_out   = 1'b1;
                    mar_load = 1'b1;
                end else if (opcode == OP_OUT) begin
                    a_out    = 1'b1;
                    out_load = 1'b1;
                end
            end
            T4: begin
                if (opcode == OP_LDA) begin
                    ram_out = 1'b1;
                    a_load  = 1'b1;
                end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ram_out = 1'b1;
                    b_load  = 1'b1;
                end
            end
            T5: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    alu_out = 1'b1;
                    a_load  = 1'b1;
                    alu_sub = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    assign tstate = state;
    assign halted = (state == HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer; runs a fixed-length and a
// variable-length instance side by side on the same stimulus.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       run = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic [3:0] opcode = 4'b0000;

    logic pc_out_f, pc_inc_f, mar_load_f, ram_out_f, ir_load_f, ir_out_f;
    logic a_load_f, a_out_f, b_load_f, alu_out_f, alu_sub_f, out_load_f, halted_f;
    logic [2:0] t_f;
    logic pc_out_v, pc_inc_v, mar_load_v, ram_out_v, ir_load_v, ir_out_v;
    logic a_load_v, a_out_v, b_load_v, alu_out_v, alu_sub_v, out_load_v, halted_v;
    logic [2:0] t_v;

    int vectors = 0;
    int miscompares = 0;
    logic chk_bus = 1'b0;

    // Strobe word bit order: pc_out pc_inc mar_load ram_out ir_load ir_out a_load a_out b_load alu_out alu_sub out_load
    localparam logic [11:0] W_NONE = 12'h000;
    localparam logic [11:0] W_T0   = 12'hA00;
    localparam logic [11:0] W_T1   = 12'h400;
    localparam logic [11:0] W_T2   = 12'h180;
    localparam logic [11:0] W_ADR  = 12'h240;
    localparam logic [11:0] W_LDA4 = 12'h120;
    localparam logic [11:0] W_ADD4 = 12'h108;
    localparam logic [11:0] W_ADD5 = 12'h024;
    localparam logic [11:0] W_SUB5 = 12'h026;
    localparam logic [11:0] W_OUT3 = 12'h011;

    logic [11:0] w_f, w_v;
    logic [4:0]  bus_f, bus_v;
    assign w_f = {pc_out_f, pc_inc_f, mar_load_f, ram_out_f, ir_load_f, ir_out_f,
                  a_load_f, a_out_f, b_load_f, alu_out_f, alu_sub_f, out_load_f};
    assign w_v = {pc_out_v, pc_inc_v, mar_load_v, ram_out_v, ir_load_v, ir_out_v,
                  a_load_v, a_out_v, b_load_v, alu_out_v, alu_sub_v, out_load_v};
    assign bus_f = {pc_out_f, ram_out_f, ir_out_f, a_out_f, alu_out_f};
    assign bus_v = {pc_out_v, ram_out_v, ir_out_v, a_out_v, alu_out_v};

    sap_control_sequencer #(.FIXED_LEN(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step_mode(step_mode),
        .step(step), .opcode(opcode),
        .pc_out(pc_out_f), .pc_inc(pc_inc_f), .mar_load(mar_load_f), .ram_out(ram_out_f),
        .ir_load(ir_load_f), .ir_out(ir_out_f), .a_load(a_load_f), .a_out(a_out_f),
        .b_load(b_load_f), .alu_out(alu_out_f), .alu_sub(alu_sub_f), .out_load(out_load_f),
        .halted(halted_f), .tstate(t_f)
    );

    sap_control_sequencer #(.FIXED_LEN(1'b0)) dut_v (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step_mode(step_mode),
        .step(step), .opcode(opcode),
        .pc_out(pc_out_v), .pc_inc(pc_inc_v), .mar_load(mar_load_v), .ram_out(ram_out_v),
        .ir_load(ir_load_v), .ir_out(ir_out_v), .a_load(a_load_v), .a_out(a_out_v),
        .b_load(b_load_v), .alu_out(alu_out_v), .alu_sub(alu_sub_v), .out_load(out_load_v),
        .halted(halted_v), .tstate(t_v)
    );

    always #5 clk = ~clk;

    // At most one bus driver in any cycle, on both instances
    always @(negedge clk) begin
        if (chk_bus) begin
            vectors++;
            if ($countones(bus_f) > 1 || $countones(bus_v) > 1) begin
                miscompares++;
                $display("FAIL bus_drivers: fixed=%b var=%b, required at most one bit set", bus_f, bus_v);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reset two cycles with run high, release, and land in T0
    task automatic start(input logic [3:0] op);
        rst_n = 1'b0; run = 1'b1; ena = 1'b1; step_mode = 1'b0; step = 1'b0; opcode = op;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; ena = 1'b0; step_mode = 1'b0; step = 1'b0; opcode = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk_bus = 1'b1;
            vectors++;
            if ({halted_f, t_f, w_f} !== {1'b0, 3'd6, W_NONE} ||
                {halted_v, t_v, w_v} !== {1'b0, 3'd6, W_NONE}) begin
                miscompares++;
                $display("FAIL reset[%0d]: f t=%0d w=%h h=%b, v t=%0d w=%h h=%b, required t=6 w=000 h=0",
                         i, t_f, w_f, halted_f, t_v, w_v, halted_v);
            end
        end
        ena = 1'b1;
        rst_n = 1'b1;
        cyc();
        vectors++;
        if ({t_f, w_f} !== {3'd0, W_T0} || {t_v, w_v} !== {3'd0, W_T0}) begin
            miscompares++;
            $display("FAIL reset_start: f t=%0d w=%h, v t=%0d w=%h, required t=0 w=%h",
                     t_f, w_f, t_v, w_v, W_T0);
        end
    endtask

    task automatic test_add();
        logic [2:0]  et [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [11:0] ew [7] = '{W_T0, W_T1, W_T2, W_ADR, W_ADD4, W_ADD5, W_T0};
        start(4'b0001);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            vectors++;
            if ({t_f, w_f} !== {et[i], ew[i]} || {t_v, w_v} !== {et[i], ew[i]}) begin
                miscompares++;
                $display("FAIL add[%0d]: f t=%0d w=%h, v t=%0d w=%h, required t=%0d w=%h",
                         i, t_f, w_f, t_v, w_v, et[i], ew[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [2:0]  et [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [11:0] ew [7] = '{W_T0, W_T1, W_T2, W_ADR, W_ADD4, W_SUB5, W_T0};
        start(4'b0010);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            vectors++;
            if ({t_v, w_v} !== {et[i], ew[i]}) begin
                miscompares++;
                $display("FAIL sub[%0d]: t=%0d w=%h, required t=%0d w=%h", i, t_v, w_v, et[i], ew[i]);
            end
        end
    endtask

    task automatic test_out_var();
        logic [2:0]  ev [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
        logic [11:0] wv [7] = '{W_T0, W_T1, W_T2, W_OUT3, W_T0, W_T1, W_T2};
        logic [2:0]  ef [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [11:0] wf [7] = '{W_T0, W_T1, W_T2, W_OUT3, W_NONE, W_NONE, W_T0};
        start(4'b1110);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            vectors++;
            if ({t_v, w_v} !== {ev[i], wv[i]} || {t_f, w_f} !== {ef[i], wf[i]}) begin
                miscompares++;
                $display("FAIL out[%0d]: v t=%0d w=%h, f t=%0d w=%h, required v t=%0d w=%h, f t=%0d w=%h",
                         i, t_v, w_v, t_f, w_f, ev[i], wv[i], ef[i], wf[i]);
            end
        end
    endtask

    task automatic test_lda_var();
        logic [2:0]  ev [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        logic [11:0] wv [7] = '{W_T0, W_T1, W_T2, W_ADR, W_LDA4, W_T0, W_T1};
        logic [2:0]  ef [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [11:0] wf [7] = '{W_T0, W_T1, W_T2, W_ADR, W_LDA4, W_NONE, W_T0};
        start(4'b0000);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            vectors++;
            if ({t_v, w_v} !== {ev[i], wv[i]} || {t_f, w_f} !== {ef[i], wf[i]}) begin
                miscompares++;
                $display("FAIL lda[%0d]: v t=%0d w=%h, f t=%0d w=%h, required v t=%0d w=%h, f t=%0d w=%h",
                         i, t_v, w_v, t_f, w_f, ev[i], wv[i], ef[i], wf[i]);
            end
        end
    endtask

    task automatic test_hlt();
        logic [2:0] et [4] = '{3'd1, 3'd2, 3'd3, 3'd7};
        start(4'b1111);
        for (int i = 0; i < 4; i++) begin
            cyc();
            vectors++;
            if ({t_f, w_f, halted_f} !== {et[i], (i == 0) ? W_T1 : (i == 1) ? W_T2 : W_NONE, i == 3} ||
                {t_v, halted_v} !== {et[i], i == 3}) begin
                miscompares++;
                $display("FAIL hlt_seq[%0d]: f t=%0d w=%h h=%b, v t=%0d h=%b, required t=%0d",
                         i, t_f, w_f, halted_f, t_v, halted_v, et[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            run = i[0]; step = i[1]; ena = ~i[2]; step_mode = i[3];
            cyc();
            vectors++;
            if ({t_f, halted_f, w_f} !== {3'd7, 1'b1, W_NONE} || {t_v, halted_v} !== {3'd7, 1'b1}) begin
                miscompares++;
                $display("FAIL hlt_hold[%0d]: f t=%0d h=%b w=%h, v t=%0d h=%b, required t=7 h=1 w=000",
                         i, t_f, halted_f, w_f, t_v, halted_v);
            end
        end
        run = 1'b1; ena = 1'b0; step = 1'b0; step_mode = 1'b0;
        rst_n = 1'b0;
        cyc();
        vectors++;
        if ({t_f, halted_f, w_f} !== {3'd6, 1'b0, W_NONE} || {t_v, halted_v} !== {3'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL hlt_reset: f t=%0d h=%b w=%h, v t=%0d h=%b, required t=6 h=0",
                     t_f, halted_f, w_f, t_v, halted_v);
        end
        ena = 1'b1;
    endtask

    task automatic test_reset_mid();
        start(4'b0001);
        repeat (4) cyc();
        vectors++;
        if (t_f !== 3'd4) begin
            miscompares++;
            $display("FAIL mid_pre: t=%0d, required t=4", t_f);
        end
        rst_n = 1'b0;
        cyc();
        vectors++;
        if ({t_f, w_f} !== {3'd6, W_NONE} || {t_v, w_v} !== {3'd6, W_NONE}) begin
            miscompares++;
            $display("FAIL mid_reset: f t=%0d w=%h, v t=%0d w=%h, required t=6 w=000",
                     t_f, w_f, t_v, w_v);
        end
    endtask

    task automatic test_single_step();
        logic [2:0] prev;
        rst_n = 1'b0; run = 1'b1; ena = 1'b1; step_mode = 1'b1; step = 1'b0; opcode = 4'b0101;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (t_f !== 3'd6) begin
            miscompares++;
            $display("FAIL step_idle: t=%0d, required t=6", t_f);
        end
        for (int p = 0; p < 3; p++) begin
            prev = (p == 0) ? 3'd6 : 3'(p - 1);
            repeat (3) begin
                cyc();
                vectors++;
                if (t_f !== prev) begin
                    miscompares++;
                    $display("FAIL step_hold[%0d]: t=%0d, required t=%0d", p, t_f, prev);
                end
            end
            step = 1'b1;
            cyc();
            step = 1'b0;
            vectors++;
            if (t_f !== 3'(p)) begin
                miscompares++;
                $display("FAIL step_adv[%0d]: t=%0d, required t=%0d", p, t_f, p);
            end
        end
        ena = 1'b0; step = 1'b1;
        cyc();
        vectors++;
        if (t_f !== 3'd2) begin
            miscompares++;
            $display("FAIL step_ena_low: t=%0d, required t=2", t_f);
        end
        ena = 1'b1;
        cyc();
        vectors++;
        if (t_f !== 3'd3) begin
            miscompares++;
            $display("FAIL step_held1: t=%0d, required t=3", t_f);
        end
        cyc();
        step = 1'b0;
        vectors++;
        if (t_f !== 3'd4) begin
            miscompares++;
            $display("FAIL step_held2: t=%0d, required t=4", t_f);
        end
        cyc();
        vectors++;
        if (t_f !== 3'd4) begin
            miscompares++;
            $display("FAIL step_release: t=%0d, required t=4", t_f);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_run_drop_nop();
        logic [2:0]  ef [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};
        logic [11:0] wf [6] = '{W_T2, W_NONE, W_NONE, W_NONE, W_NONE, W_NONE};
        logic [2:0]  ev [6] = '{3'd2, 3'd3, 3'd6, 3'd6, 3'd6, 3'd6};
        start(4'b0101);
        cyc();
        vectors++;
        if ({t_f, w_f} !== {3'd1, W_T1}) begin
            miscompares++;
            $display("FAIL nop_t1: t=%0d w=%h, required t=1 w=%h", t_f, w_f, W_T1);
        end
        run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            vectors++;
            if ({t_f, w_f} !== {ef[i], wf[i]} || t_v !== ev[i]) begin
                miscompares++;
                $display("FAIL nop_drop[%0d]: f t=%0d w=%h, v t=%0d, required f t=%0d w=%h, v t=%0d",
                         i, t_f, w_f, t_v, ef[i], wf[i], ev[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_out_var();
        test_lda_var();
        test_hlt();
        test_reset_mid();
        test_single_step();
        test_run_drop_nop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
